// File: rtl/branch_prediction_gshare_pkg.sv
// Shared definitions for the gshare branch predictor: reset level and BTB entry types.
package branch_prediction_gshare_pkg;

   localparam logic RST_EN = 1'b0;

   typedef enum logic [1:0] {
      BP_TYPE_COND = 2'd0,
      BP_TYPE_JMP  = 2'd1,
      BP_TYPE_CALL = 2'd2,
      BP_TYPE_RET  = 2'd3
   } bp_type_e;

endpackage

// File: rtl/branch_prediction_gshare_ras.sv
// Return address stack with a speculative and a proven ptr/count pair sharing one circular array.
module bp_ras
   import branch_prediction_gshare_pkg::*;
#(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned NUM_ENTRIES = 8
) (
   input  logic                             clk_i,
   input  logic                             n_rst_i,
   input  logic                             push_i,
   input  logic                             pop_i,
   input  logic [PC_WIDTH-1:0]              push_addr_i,
   input  logic                             proven_push_i,
   input  logic                             proven_pop_i,
   input  logic                             recover_i,
   input  logic                             recover_write_i,
   input  logic [PC_WIDTH-1:0]              recover_addr_i,
   output logic [PC_WIDTH-1:0]              top_o,
   output logic [$clog2(NUM_ENTRIES):0]     count_o
);

   localparam int unsigned RW = $clog2(NUM_ENTRIES);
   typedef logic [RW-1:0] ptr_t;
   typedef logic [RW:0]   cnt_t;
   localparam cnt_t FULL = cnt_t'(NUM_ENTRIES);

   logic [PC_WIDTH-1:0] ras_q [NUM_ENTRIES];
   ptr_t spec_ptr_q, prv_ptr_q, prv_ptr_d;
   cnt_t spec_cnt_q, prv_cnt_q, prv_cnt_d;

   always_comb begin
      prv_ptr_d = prv_ptr_q;
      prv_cnt_d = prv_cnt_q;
      if (proven_push_i) begin
         prv_ptr_d = prv_ptr_q + ptr_t'(1);
         if (prv_cnt_q != FULL) prv_cnt_d = prv_cnt_q + cnt_t'(1);
      end else if (proven_pop_i && prv_cnt_q != '0) begin
         prv_ptr_d = prv_ptr_q - ptr_t'(1);
         prv_cnt_d = prv_cnt_q - cnt_t'(1);
      end
   end

   // Recovery restores from the proven copy after this cycle's update and suppresses speculative push/pop.
   always_ff @(posedge clk_i) begin
      if (n_rst_i == RST_EN) begin
         spec_ptr_q <= '0;
         spec_cnt_q <= '0;
         prv_ptr_q  <= '0;
         prv_cnt_q  <= '0;
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) ras_q[i] <= '0;
      end else begin
         prv_ptr_q <= prv_ptr_d;
         prv_cnt_q <= prv_cnt_d;
         if (recover_i) begin
            spec_ptr_q <= prv_ptr_d;
            spec_cnt_q <= prv_cnt_d;
            if (recover_write_i) ras_q[prv_ptr_d] <= recover_addr_i;
         end else if (push_i) begin
            spec_ptr_q <= spec_ptr_q + ptr_t'(1);
            ras_q[spec_ptr_q + ptr_t'(1)] <= push_addr_i;
            if (spec_cnt_q != FULL) spec_cnt_q <= spec_cnt_q + cnt_t'(1);
         end else if (pop_i && spec_cnt_q != '0) begin
            spec_ptr_q <= spec_ptr_q - ptr_t'(1);
            spec_cnt_q <= spec_cnt_q - cnt_t'(1);
         end
      end
   end

   assign top_o   = ras_q[spec_ptr_q];
   assign count_o = spec_cnt_q;

endmodule

// File: rtl/branch_prediction_gshare.sv
// Fetch-stage predictor: gshare PHT, direct-mapped tagged BTB and a return address stack.
module branch_prediction_gshare
   import branch_prediction_gshare_pkg::*;
#(
   parameter int unsigned PC_WIDTH        = 32,
   parameter int unsigned GHR_WIDTH       = 8,
   parameter int unsigned NUM_PHT_ENTRIES = 256,
   parameter int unsigned NUM_BTB_ENTRIES = 64,
   parameter int unsigned NUM_RAS_ENTRIES = 8
) (
   input  logic                 clk_i,
   input  logic                 n_rst_i,
   input  logic [PC_WIDTH-1:0]  pc_i,
   input  logic                 stall_i,
   input  logic                 branch_request_i,
   input  logic [PC_WIDTH-1:0]  branch_source_i,
   input  logic [PC_WIDTH-1:0]  branch_target_i,
   input  logic                 branch_is_taken_i,
   input  logic                 branch_is_call_i,
   input  logic                 branch_is_ret_i,
   input  logic                 branch_is_jmp_i,
   input  logic                 branch_mispredict_i,
   input  logic [GHR_WIDTH-1:0] branch_ghr_i,
   output logic [PC_WIDTH-1:0]  next_pc_o,
   output logic                 next_taken_o,
   output logic [GHR_WIDTH-1:0] pred_ghr_o
);

   localparam int unsigned P  = $clog2(NUM_PHT_ENTRIES);
   localparam int unsigned B  = $clog2(NUM_BTB_ENTRIES);
   localparam int unsigned TW = PC_WIDTH - 2 - B;
   localparam int unsigned RW = $clog2(NUM_RAS_ENTRIES);

   logic [1:0]          pht_q        [NUM_PHT_ENTRIES];
   logic                btb_valid_q  [NUM_BTB_ENTRIES];
   logic [TW-1:0]       btb_tag_q    [NUM_BTB_ENTRIES];
   logic [PC_WIDTH-1:0] btb_target_q [NUM_BTB_ENTRIES];
   bp_type_e            btb_type_q   [NUM_BTB_ENTRIES];
   logic [GHR_WIDTH-1:0] spec_ghr_q, spec_ghr_d;

   logic [B-1:0]        rd_btb_idx, wr_btb_idx;
   logic [P-1:0]        rd_pht_idx, wr_pht_idx;
   logic [PC_WIDTH-1:0] pc_plus4, ras_top;
   logic [RW:0]         ras_count;
   logic                btb_hit, pred_dir, cond_hit, call_hit, ret_hit;
   logic                req_cond, recover;
   bp_type_e            hit_type, wr_type;

   assign pc_plus4   = pc_i + PC_WIDTH'(4);
   assign rd_btb_idx = pc_i[2 +: B];
   assign rd_pht_idx = pc_i[2 +: P] ^ P'(spec_ghr_q);
   assign btb_hit    = btb_valid_q[rd_btb_idx] && (btb_tag_q[rd_btb_idx] == pc_i[PC_WIDTH-1 -: TW]);
   assign hit_type   = btb_type_q[rd_btb_idx];
   assign pred_dir   = pht_q[rd_pht_idx][1];

   assign req_cond   = branch_request_i && !(branch_is_call_i || branch_is_ret_i || branch_is_jmp_i);
   assign recover    = branch_request_i && branch_mispredict_i;
   assign wr_btb_idx = branch_source_i[2 +: B];
   assign wr_pht_idx = branch_source_i[2 +: P] ^ P'(branch_ghr_i);
   assign wr_type    = branch_is_call_i ? BP_TYPE_CALL :
                       branch_is_ret_i  ? BP_TYPE_RET  :
                       branch_is_jmp_i  ? BP_TYPE_JMP  : BP_TYPE_COND;

   always_comb begin
      next_pc_o    = pc_plus4;
      next_taken_o = 1'b0;
      cond_hit     = 1'b0;
      call_hit     = 1'b0;
      ret_hit      = 1'b0;
      if (btb_hit) begin
         case (hit_type)
            BP_TYPE_RET: begin
               ret_hit = 1'b1;
               if (ras_count != '0) begin
                  next_pc_o    = ras_top;
                  next_taken_o = 1'b1;
               end
            end
            BP_TYPE_CALL, BP_TYPE_JMP: begin
               call_hit     = (hit_type == BP_TYPE_CALL);
               next_pc_o    = btb_target_q[rd_btb_idx];
               next_taken_o = 1'b1;
            end
            BP_TYPE_COND: begin
               cond_hit = 1'b1;
               if (pred_dir) begin
                  next_pc_o    = btb_target_q[rd_btb_idx];
                  next_taken_o = 1'b1;
               end
            end
         endcase
      end
   end

   // Mispredict recovery takes precedence over the speculative shift.
   always_comb begin
      spec_ghr_d = spec_ghr_q;
      if (recover)
         spec_ghr_d = req_cond ? {branch_ghr_i[GHR_WIDTH-2:0], branch_is_taken_i} : branch_ghr_i;
      else if (cond_hit && !stall_i)
         spec_ghr_d = {spec_ghr_q[GHR_WIDTH-2:0], pred_dir};
   end

   always_ff @(posedge clk_i) begin
      if (n_rst_i == RST_EN) spec_ghr_q <= '0;
      else                   spec_ghr_q <= spec_ghr_d;
   end

   always_ff @(posedge clk_i) begin
      if (n_rst_i == RST_EN) begin
         for (int unsigned i = 0; i < NUM_PHT_ENTRIES; i++) pht_q[i] <= 2'b01;
      end else if (req_cond) begin
         if (branch_is_taken_i && pht_q[wr_pht_idx] != 2'b11)
            pht_q[wr_pht_idx] <= pht_q[wr_pht_idx] + 2'b01;
         else if (!branch_is_taken_i && pht_q[wr_pht_idx] != 2'b00)
            pht_q[wr_pht_idx] <= pht_q[wr_pht_idx] - 2'b01;
      end
   end

   always_ff @(posedge clk_i) begin
      if (n_rst_i == RST_EN) begin
         for (int unsigned i = 0; i < NUM_BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
      end else if (branch_request_i && branch_is_taken_i) begin
         btb_valid_q[wr_btb_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (n_rst_i != RST_EN && branch_request_i && branch_is_taken_i) begin
         btb_tag_q[wr_btb_idx]    <= branch_source_i[PC_WIDTH-1 -: TW];
         btb_target_q[wr_btb_idx] <= branch_target_i;
         btb_type_q[wr_btb_idx]   <= wr_type;
      end
   end

   bp_ras #(
      .PC_WIDTH    (PC_WIDTH),
      .NUM_ENTRIES (NUM_RAS_ENTRIES)
   ) u_ras (
      .clk_i           (clk_i),
      .n_rst_i         (n_rst_i),
      .push_i          (call_hit && !stall_i),
      .pop_i           (ret_hit && !stall_i),
      .push_addr_i     (pc_plus4),
      .proven_push_i   (branch_request_i && branch_is_call_i),
      .proven_pop_i    (branch_request_i && branch_is_ret_i && !branch_is_call_i),
      .recover_i       (recover),
      .recover_write_i (recover && branch_is_call_i),
      .recover_addr_i  (branch_source_i + PC_WIDTH'(4)),
      .top_o           (ras_top),
      .count_o         (ras_count)
   );

   assign pred_ghr_o = spec_ghr_q;

endmodule
